// File: rtl/md_issue_ctrl.sv
// D->E issue/stall controller for the HILO multiply/divide unit.
// A shadow countdown mirrors the unit's busy window, so md-class ops in D wait until HILO is free.
module md_issue_ctrl #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10,
    parameter int unsigned TYPE_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              D_valid,
    input  logic [TYPE_W-1:0] D_md_op,
    output logic [TYPE_W-1:0] E_Type,
    output logic              md_busy,
    output logic              stall_D,
    output logic [31:0]       stall_cnt
);

    localparam int unsigned MaxLat = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
    localparam int unsigned CntRaw = $clog2(MaxLat + 2);
    localparam int unsigned CntW   = (CntRaw < 5) ? 5 : CntRaw;

    logic [TYPE_W-1:0] e_type_q, e_type_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [31:0]       stall_cnt_q, stall_cnt_d;
    logic              busy;
    logic              d_md;
    logic              e_unstarted;

    function automatic logic is_start(input logic [TYPE_W-1:0] op);
        return (op >= TYPE_W'(1)) && (op <= TYPE_W'(4));
    endfunction

    function automatic logic is_md(input logic [TYPE_W-1:0] op);
        return (op >= TYPE_W'(1)) && (op <= TYPE_W'(8));
    endfunction

    // Value cnt takes on the cycle the op sits in E (HILO start cycle).
    function automatic logic [CntW-1:0] start_val(input logic [TYPE_W-1:0] op);
        if ((op == TYPE_W'(1)) || (op == TYPE_W'(2))) begin
            return CntW'(MULT_CYC + 1);
        end
        return CntW'(DIV_CYC + 1);
    endfunction

    always_comb begin
        busy        = (cnt_q != '0);
        d_md        = D_valid & is_md(D_md_op);
        stall_D     = d_md & busy & ~req;
        e_unstarted = is_start(e_type_q) & (cnt_q == start_val(e_type_q));
    end

    always_comb begin
        e_type_d = '0;
        if (req) begin
            e_type_d = '0;
        end else if (stall_D) begin
            e_type_d = '0;
        end else if (D_valid) begin
            e_type_d = D_md_op;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (req && e_unstarted) begin
            // Op flushed before HILO ever started it.
            cnt_d = '0;
        end else if (req) begin
            cnt_d = cnt_q;
        end else if (busy) begin
            cnt_d = cnt_q - CntW'(1);
        end else if (D_valid && is_start(D_md_op)) begin
            cnt_d = start_val(D_md_op);
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_D && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            e_type_q    <= '0;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            e_type_q    <= e_type_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign E_Type    = e_type_q;
    assign md_busy   = busy;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl; a small HILO busy model is compared against md_busy each cycle.
module tb_md_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        D_valid;
    logic [3:0]  D_md_op;
    logic [3:0]  E_Type;
    logic        md_busy;
    logic        stall_D;
    logic [31:0] stall_cnt;

    int n_checks = 0;
    int n_errors = 0;
    logic busy_chk_en = 1'b0;

    md_issue_ctrl #(
        .MULT_CYC (5),
        .DIV_CYC  (10),
        .TYPE_W   (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .D_valid   (D_valid),
        .D_md_op   (D_md_op),
        .E_Type    (E_Type),
        .md_busy   (md_busy),
        .stall_D   (stall_D),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    // HILO unit busy model: start cycle plus LAT countdown cycles, frozen while req.
    logic [4:0] h_cnt;
    logic       h_start;
    logic       hilo_busy;
    assign h_start   = (E_Type >= 4'd1) && (E_Type <= 4'd4);
    assign hilo_busy = h_start | (h_cnt != 5'd0);

    always @(posedge clk) begin
        if (!reset) begin
            h_cnt <= 5'd0;
        end else if (!req) begin
            if (h_cnt != 5'd0) begin
                h_cnt <= h_cnt - 5'd1;
            end else if (h_start) begin
                h_cnt <= (E_Type <= 4'd2) ? 5'd5 : 5'd10;
            end
        end
    end

    always @(negedge clk) begin
        if (busy_chk_en) begin
            n_checks++;
            assert (md_busy === hilo_busy) else begin
                n_errors++;
                $error("FAIL md_busy_vs_hilo: got %0b expected %0b at %0t", md_busy, hilo_busy,
                       $time);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        req     = 1'b0;
        D_valid = 1'b0;
        D_md_op = 4'd0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("reset_etype", 32'(E_Type), 32'd0);
        chk("reset_busy", 32'(md_busy), 32'd0);
        chk("reset_stall", 32'(stall_D), 32'd0);
        chk("reset_stallcnt", stall_cnt, 32'd0);
        busy_chk_en = 1'b1;

        // mult then mflo: 6 stall cycles
        D_valid = 1'b1;
        D_md_op = 4'd1;
        #1;
        chk("mult_nostall", 32'(stall_D), 32'd0);
        tick();
        chk("mult_in_e", 32'(E_Type), 32'd1);
        chk("mult_busy", 32'(md_busy), 32'd1);
        D_md_op = 4'd6;
        #1;
        repeat (6) begin
            chk("mflo_stall", 32'(stall_D), 32'd1);
            tick();
            chk("mflo_bubble", 32'(E_Type), 32'd0);
        end
        chk("mflo_release", 32'(stall_D), 32'd0);
        chk("mult_done", 32'(md_busy), 32'd0);
        tick();
        chk("mflo_issued", 32'(E_Type), 32'd6);
        chk("stallcnt_6", stall_cnt, 32'd6);
        D_valid = 1'b0;
        tick();

        // divu then mfhi: 11 stall cycles
        D_valid = 1'b1;
        D_md_op = 4'd4;
        tick();
        chk("divu_in_e", 32'(E_Type), 32'd4);
        D_md_op = 4'd5;
        #1;
        repeat (11) begin
            chk("mfhi_stall", 32'(stall_D), 32'd1);
            tick();
            chk("mfhi_bubble", 32'(E_Type), 32'd0);
        end
        chk("mfhi_release", 32'(stall_D), 32'd0);
        tick();
        chk("mfhi_issued", 32'(E_Type), 32'd5);
        chk("stallcnt_17", stall_cnt, 32'd17);
        D_valid = 1'b0;
        tick();

        // req while mult sits in E cancels it
        D_valid = 1'b1;
        D_md_op = 4'd1;
        tick();
        D_valid = 1'b0;
        req     = 1'b1;
        #1;
        chk("cancel_busy_pre", 32'(md_busy), 32'd1);
        tick();
        chk("cancel_etype", 32'(E_Type), 32'd0);
        chk("cancel_busy", 32'(md_busy), 32'd0);
        req     = 1'b0;
        D_valid = 1'b1;
        D_md_op = 4'd6;
        #1;
        chk("cancel_mflo_nostall", 32'(stall_D), 32'd0);
        tick();
        chk("cancel_mflo_issued", 32'(E_Type), 32'd6);
        D_valid = 1'b0;
        tick();

        // div with 3-cycle req at cnt=7: countdown frozen, 11 non-req stall cycles
        D_valid = 1'b1;
        D_md_op = 4'd3;
        tick();
        D_md_op = 4'd5;
        #1;
        repeat (4) begin
            chk("divreq_stall_a", 32'(stall_D), 32'd1);
            tick();
        end
        req = 1'b1;
        #1;
        repeat (3) begin
            chk("divreq_req_nostall", 32'(stall_D), 32'd0);
            chk("divreq_req_busy", 32'(md_busy), 32'd1);
            tick();
            chk("divreq_req_etype", 32'(E_Type), 32'd0);
        end
        req = 1'b0;
        #1;
        repeat (7) begin
            chk("divreq_stall_b", 32'(stall_D), 32'd1);
            tick();
        end
        chk("divreq_release", 32'(stall_D), 32'd0);
        tick();
        chk("divreq_mfhi_issued", 32'(E_Type), 32'd5);
        chk("stallcnt_28", stall_cnt, 32'd28);

        // mthi then mfhi: no stall
        D_md_op = 4'd7;
        tick();
        chk("mthi_in_e", 32'(E_Type), 32'd7);
        chk("mthi_nobusy", 32'(md_busy), 32'd0);
        D_md_op = 4'd5;
        #1;
        chk("mthi_mfhi_nostall", 32'(stall_D), 32'd0);
        tick();
        chk("mthi_mfhi_issued", 32'(E_Type), 32'd5);
        chk("stallcnt_still_28", stall_cnt, 32'd28);

        // reset mid-countdown at cnt=4
        D_md_op = 4'd3;
        tick();
        D_valid = 1'b0;
        repeat (7) tick();
        chk("pre_reset_busy", 32'(md_busy), 32'd1);
        reset = 1'b0;
        tick();
        reset   = 1'b1;
        D_valid = 1'b1;
        D_md_op = 4'd5;
        #1;
        chk("midreset_etype", 32'(E_Type), 32'd0);
        chk("midreset_busy", 32'(md_busy), 32'd0);
        chk("midreset_stall", 32'(stall_D), 32'd0);
        chk("midreset_stallcnt", stall_cnt, 32'd0);
        tick();

        // saturation of stall_cnt
        D_md_op = 4'd1;
        tick();
        D_md_op = 4'd6;
        @(negedge clk);
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt_q;
        #1;
        chk("sat_stall", 32'(stall_D), 32'd1);
        chk("sat_pre", stall_cnt, 32'hFFFF_FFFF);
        tick();
        chk("sat_hold", stall_cnt, 32'hFFFF_FFFF);
        D_valid = 1'b0;
        repeat (8) tick();

        busy_chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
